// File: rtl/mod_reduce.sv
// Bit-serial modular reduction: product mod modulus by restoring shift-subtract,
// consuming one product bit per clock, MSB first.
module mod_reduce #(
    parameter int unsigned DATA_WIDTH = 2048,
    localparam int unsigned CNT_W = $clog2(2 * DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*DATA_WIDTH-1:0]   product,
    input  logic [DATA_WIDTH-1:0]     modulus,
    input  logic                      vld_in,
    output logic                      rdy_in,
    output logic                      busy,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                    state_q, state_d;
    logic [2*DATA_WIDTH-1:0]   prod_q, prod_d;
    logic [DATA_WIDTH-1:0]     mod_q, mod_d;
    logic [DATA_WIDTH-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    // rem < N keeps the shifted remainder within DATA_WIDTH+1 bits, and t-N within DATA_WIDTH.
    logic [DATA_WIDTH:0]       t;
    logic [DATA_WIDTH-1:0]     rem_step;

    always_comb begin
        t        = {rem_q, prod_q[cnt_q]};
        rem_step = (t >= {1'b0, mod_q}) ? DATA_WIDTH'(t - {1'b0, mod_q}) : t[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        mod_d    = mod_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (vld_in) begin
                    prod_d = product;
                    mod_d  = modulus;
                    rem_d  = '0;
                    err_d  = 1'b0;
                    cnt_d  = CNT_W'(2 * DATA_WIDTH - 1);
                    if (modulus != '0) begin
                        state_d = StBusy;
                    end else begin
                        // Division by zero: flag immediately without entering the datapath.
                        result_d = '0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            StBusy: begin
                rem_d = rem_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d = rem_step;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            prod_q   <= '0;
            mod_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            mod_q    <= mod_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rdy_in = (state_q == StIdle);
    assign busy   = (state_q == StBusy);
    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: doc/mod_reduce.md
Name: mod_reduce

Overview:
- Bit-serial modular reduction stage placed directly downstream of the shift-add multiplier.
- Takes the 2*DATA_WIDTH-bit product and a DATA_WIDTH-bit modulus, and returns product mod modulus.
- Uses restoring shift-subtract, one product bit per clock, MSB first.
- Together with the multiplier it forms the modular-multiply datapath for the big-number exponentiation engine.

Parameters:
DATA_WIDTH, 2048, operand/modulus width; product input is 2*DATA_WIDTH bits; must be >= 2
CNT_W, $clog2(2*DATA_WIDTH), bit-index counter width (derived, not overridden)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous active-high reset
product  input  2*DATA_WIDTH  value to reduce, sampled on accept
modulus  input  DATA_WIDTH  reduction modulus N, sampled on accept
vld_in  input  1  request strobe; accepted when rdy_in=1
rdy_in  output  1  high while IDLE (able to accept)
busy  output  1  high while a reduction is in progress
result  output  DATA_WIDTH  product mod N; held until the next done
done  output  1  one-cycle pulse, result valid
err  output  1  set with done when N==0; cleared on the next accept

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst), sampled only on a clk rising edge.
- Reset values: state=IDLE, rdy_in=1, busy=0, done=0, err=0, result=0, internal remainder/counter/operand registers=0.
- FSM states: IDLE, BUSY.
- Accept: an edge with state=IDLE and vld_in=1.
  - Latch product and modulus.
  - Clear rem to 0 and err to 0.
  - Set cnt to 2*DATA_WIDTH-1.
  - If modulus!=0: go to BUSY.
  - If modulus==0: stay IDLE and, on that same edge, set result<=0, err<=1, done<=1.
- BUSY, each edge:
  - t = {rem,prod_q[cnt]}, i.e. 2*rem + bit, DATA_WIDTH+1 bits wide.
  - rem <= (t >= {1'b0,N}) ? t-N : t[DATA_WIDTH-1:0].
  - cnt <= cnt-1.
- Width rule: rem < N < 2^DATA_WIDTH always holds, so t fits in DATA_WIDTH+1 bits and t-N fits in DATA_WIDTH bits; no truncation is allowed.
- Completion: on the BUSY edge where cnt==0:
  - result <= final rem (the same expression computed that cycle);
  - done <= 1;
  - state <= IDLE.
- Latency: done is high in the cycle after the 2*DATA_WIDTH-th edge following the accept edge, i.e. exactly 2*DATA_WIDTH cycles after accept. The N==0 case completes in 1 cycle.
- done is a single-cycle pulse, deasserted on the next edge unless a new completion occurs.
- result and err hold their values between completions.
- busy = (state==BUSY); rdy_in = (state==IDLE). Both are combinational from the state register.
- vld_in while BUSY: ignored, with no effect on the datapath or the result. Upstream must hold the request until rdy_in=1.
- Back-to-back: in the done cycle the state is already IDLE, so a vld_in in that cycle is accepted. done and the new capture coexist; result is not disturbed until the next completion.
- Input changes after accept have no effect, because operands are registered.
- Reset mid-operation: on the rst edge, return to IDLE and apply all reset values; the partial result is discarded and no done is issued.
- rst has priority over vld_in on the same edge.

Test Plan:
1. Basic reduction (DATA_WIDTH=8): product=0x1234, modulus=0xC5, vld_in 1 cycle -> busy for 16 cycles, then done pulse with result=0x81, err=0.
2. Max product (DATA_WIDTH=8): product=0xFFFF, modulus=0xFF -> result=0x00 after 16 cycles; then product=0xFFFF, modulus=0xFE -> result=0x03.
3. Product smaller than modulus (DATA_WIDTH=8): product=0x0042, modulus=0x80 -> result=0x42. Also product=0x0000, modulus=0x01 -> result=0x00.
4. Zero modulus: modulus=0x00, any product -> done and err=1 on the cycle after accept, result=0x00, busy never set. The next valid request clears err.
5. Protocol (DATA_WIDTH=8):
   - vld_in pulsed mid-BUSY with different operands -> ignored; the first request's result is still 0x81.
   - vld_in held high through the done cycle -> the second request is accepted in the done cycle, and its done follows 16 cycles later.
6. Reset mid-operation: assert rst at cycle 7 of BUSY -> next edge gives rdy_in=1, busy=0, result=0, no done. A fresh request (0x1234 mod 0xC5) then completes normally with 0x81.
7. Randomized (DATA_WIDTH=64 and 2048): result compared against a reference model (product % modulus) over 1000 vectors, including modulus=1 and modulus=2^W-1.
